regfile_wb_arbiter: RTL

Shares the register file's single write port (write address, write data, write enable) between two writeback producers: the ALU result path and the memory-load path. Each producer has a valid/ready handshake into a small per-producer queue. A round-robin arbiter drains one queued write per cycle onto registered write-port outputs. A 32-bit pending-write mask lets decode stall reads of registers that still have writes in flight. The block sits between the execute/memory stages and the 32×32 register file.

---
 rtl/regfile_wb_arbiter_pkg.sv | 26 ++
 rtl/regfile_wb_arbiter_if.sv | 35 +++
 rtl/regfile_wb_arbiter_fifo.sv | 72 +++++++
 rtl/regfile_wb_arbiter.sv | 125 ++++++++++++
 4 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and sizes for the register-file writeback arbiter.
// Entries carry a destination register and its write data.
package regfile_wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int NUM_REGS   = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_entry_t;

    typedef enum logic {
        GRANT_ALU = 1'b0,
        GRANT_MEM = 1'b1
    } grant_t;

    function automatic logic [NUM_REGS-1:0] addr_onehot(input logic [REG_ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] oh;
        oh       = '0;
        oh[addr] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// Producer handshakes, register-file write port and pending-write mask.
// The arbiter is the slave; execute/memory stages and the register file form the master side.
interface regfile_wb_arbiter_if;
    import regfile_wb_pkg::*;

    logic                  alu_valid;
    logic                  alu_ready;
    logic [REG_ADDR_W-1:0] alu_addr;
    logic [DATA_W-1:0]     alu_data;

    logic                  mem_valid;
    logic                  mem_ready;
    logic [REG_ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0]     mem_data;

    logic [REG_ADDR_W-1:0] rf_aw;
    logic [DATA_W-1:0]     rf_dw;
    logic                  rf_wren;
    logic [NUM_REGS-1:0]   busy_mask;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        input  alu_ready, mem_ready,
        input  rf_aw, rf_dw, rf_wren, busy_mask
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        output alu_ready, mem_ready,
        output rf_aw, rf_dw, rf_wren, busy_mask
    );

endinterface

// File: rtl/regfile_wb_arbiter_fifo.sv
// Per-producer writeback queue: shift-down FIFO, head always in slot 0.
// Slot addresses and occupancy are exported so the top can build the pending-write mask.
module wb_fifo
    import regfile_wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    push,
    input  wb_entry_t                               push_entry,
    input  logic                                    pop,
    output logic                                    full,
    output logic                                    empty,
    output wb_entry_t                               head,
    output logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0]   entry_addr,
    output logic [FIFO_DEPTH-1:0]                   entry_valid
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [CNT_W-1:0]             cnt_q;
    logic [CNT_W-1:0]             wr_idx;
    wb_entry_t [FIFO_DEPTH-1:0]   slot_q;
    wb_entry_t [FIFO_DEPTH-1:0]   slot_shift;
    wb_entry_t [FIFO_DEPTH-1:0]   slot_d;

    assign full  = (cnt_q == CNT_W'(FIFO_DEPTH));
    assign empty = (cnt_q == '0);
    assign head  = slot_q[0];

    // A simultaneous pop frees slot 0, so the new entry lands one slot lower.
    assign wr_idx = pop ? (cnt_q - CNT_W'(1)) : cnt_q;

    always_comb begin
        slot_shift = slot_q;
        for (int i = 0; i < FIFO_DEPTH - 1; i++) begin
            slot_shift[i] = slot_q[i+1];
        end
    end

    always_comb begin
        slot_d = pop ? slot_shift : slot_q;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (push && (wr_idx == CNT_W'(i))) begin
                slot_d[i] = push_entry;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            entry_addr[i]  = slot_q[i].addr;
            entry_valid[i] = (cnt_q > CNT_W'(i));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (push && !pop) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end else if (pop && !push) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        slot_q <= slot_d;
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register file write port between ALU and load writeback.
// An arriving write with an empty queue bypasses straight to the output register.
module regfile_wb_arbiter
    import regfile_wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    regfile_wb_arbiter_if.slave  bus
);

    logic                                   alu_full, alu_empty, mem_full, mem_empty;
    logic                                   alu_ready, mem_ready;
    logic                                   alu_in_vld, mem_in_vld;
    logic                                   alu_cand_vld, mem_cand_vld;
    logic                                   alu_push, mem_push, alu_pop, mem_pop;
    logic                                   grant_alu, grant_mem, conflict;
    wb_entry_t                              alu_in, mem_in, alu_head, mem_head;
    wb_entry_t                              alu_cand, mem_cand, win;
    logic [FIFO_DEPTH-1:0][REG_ADDR_W-1:0]  alu_addrs, mem_addrs;
    logic [FIFO_DEPTH-1:0]                  alu_vlds, mem_vlds;
    grant_t                                 last_grant_q;
    logic                                   vld_p1;
    wb_entry_t                              entry_p1;
    logic [NUM_REGS-1:0]                    busy;

    // ---- stage 0: handshake, candidate selection, arbitration ----
    assign alu_ready = !reset && !alu_full;
    assign mem_ready = !reset && !mem_full;

    // Address-0 writes complete the handshake but are never queued or issued.
    assign alu_in_vld = bus.alu_valid && alu_ready && (bus.alu_addr != '0);
    assign mem_in_vld = bus.mem_valid && mem_ready && (bus.mem_addr != '0);

    assign alu_in = '{addr: bus.alu_addr, data: bus.alu_data};
    assign mem_in = '{addr: bus.mem_addr, data: bus.mem_data};

    assign alu_cand_vld = !alu_empty || alu_in_vld;
    assign mem_cand_vld = !mem_empty || mem_in_vld;
    assign alu_cand     = alu_empty ? alu_in : alu_head;
    assign mem_cand     = mem_empty ? mem_in : mem_head;

    assign conflict  = alu_cand_vld && mem_cand_vld;
    assign grant_alu = alu_cand_vld && (!mem_cand_vld || (last_grant_q == GRANT_MEM));
    assign grant_mem = mem_cand_vld && !grant_alu;

    // Queued heads pop; a granted arrival into an empty queue bypasses it.
    assign alu_pop  = grant_alu && !alu_empty;
    assign mem_pop  = grant_mem && !mem_empty;
    assign alu_push = alu_in_vld && !(grant_alu && alu_empty);
    assign mem_push = mem_in_vld && !(grant_mem && mem_empty);

    always_comb begin
        win = '0;
        if (grant_alu) begin
            win = alu_cand;
        end else if (grant_mem) begin
            win = mem_cand;
        end
    end

    // Priority only rotates when both producers actually competed.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= GRANT_ALU;
        end else if (conflict) begin
            last_grant_q <= grant_alu ? GRANT_ALU : GRANT_MEM;
        end
    end

    wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (alu_push),
        .push_entry  (alu_in),
        .pop         (alu_pop),
        .full        (alu_full),
        .empty       (alu_empty),
        .head        (alu_head),
        .entry_addr  (alu_addrs),
        .entry_valid (alu_vlds)
    );

    wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_mem_fifo (
        .clk         (clk),
        .reset       (reset),
        .push        (mem_push),
        .push_entry  (mem_in),
        .pop         (mem_pop),
        .full        (mem_full),
        .empty       (mem_empty),
        .head        (mem_head),
        .entry_addr  (mem_addrs),
        .entry_valid (mem_vlds)
    );

    // ---- stage 1: registered write port ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1   <= 1'b0;
            entry_p1 <= '0;
        end else begin
            vld_p1   <= grant_alu || grant_mem;
            entry_p1 <= win;
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (alu_vlds[i]) busy = busy | addr_onehot(alu_addrs[i]);
            if (mem_vlds[i]) busy = busy | addr_onehot(mem_addrs[i]);
        end
        if (vld_p1) busy = busy | addr_onehot(entry_p1.addr);
    end

    assign bus.alu_ready = alu_ready;
    assign bus.mem_ready = mem_ready;
    assign bus.rf_aw     = entry_p1.addr;
    assign bus.rf_dw     = entry_p1.data;
    assign bus.rf_wren   = vld_p1;
    assign bus.busy_mask = busy;

endmodule
